// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: fixed-priority ALU writes merged with
// a FIFO of load returns, with WAW cancel and pending-write query flags.
module writeback_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  AluValid,
  input  logic [4:0]            AluRd,
  input  logic [DATA_WIDTH-1:0] AluData,
  input  logic                  MemValid,
  output logic                  MemReady,
  input  logic [4:0]            MemRd,
  input  logic [DATA_WIDTH-1:0] MemData,
  input  logic [4:0]            QueryA,
  input  logic [4:0]            QueryB,
  output logic                  PendA,
  output logic                  PendB,
  output logic [CW-1:0]         Count,
  output logic [4:0]            RW,
  output logic [DATA_WIDTH-1:0] BusW,
  output logic                  RegWr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [4:0] X31 = 5'd31;

  logic [4:0]            r_rd   [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]      r_live;
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_regwr;
  logic [4:0]            r_rw;
  logic [DATA_WIDTH-1:0] r_busw;

  logic             w_alu;
  logic             w_push;
  logic             w_pop;
  logic             w_head_live;
  logic [DEPTH-1:0] w_hit_a;
  logic [DEPTH-1:0] w_hit_b;
  logic [DEPTH-1:0] w_cancel;

  assign MemReady    = !Reset && (r_count < FULL);
  assign w_alu       = AluValid && (AluRd != X31);
  assign w_push      = MemValid && MemReady && (MemRd != X31);
  assign w_pop       = !w_alu && (r_count != '0);
  assign w_head_live = r_live[r_rptr];

  always_comb begin
    w_hit_a  = '0;
    w_hit_b  = '0;
    w_cancel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_hit_a[i]  = r_live[i] && (r_rd[i] == QueryA);
      w_hit_b[i]  = r_live[i] && (r_rd[i] == QueryB);
      w_cancel[i] = w_alu && (r_rd[i] == AluRd);
    end
  end

  assign PendA = (QueryA != X31) && (|w_hit_a);
  assign PendB = (QueryB != X31) && (|w_hit_b);
  assign Count = r_count;
  assign RW    = r_rw;
  assign BusW  = r_busw;
  assign RegWr = r_regwr;

  // Payload storage needs no reset; only live bits mark valid entries.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_rd[r_wptr]   <= MemRd;
      r_data[r_wptr] <= MemData;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_live  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_regwr <= 1'b0;
      r_rw    <= X31;
      r_busw  <= '0;
    end else begin
      // Cancel first, so a same-cycle push (younger) keeps its live bit.
      r_live <= r_live & ~w_cancel;
      if (w_pop) begin
        r_live[r_rptr] <= 1'b0;
        r_rptr         <= r_rptr + AW'(1);
      end
      if (w_push) begin
        r_live[r_wptr] <= 1'b1;
        r_wptr         <= r_wptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_alu) begin
        r_regwr <= 1'b1;
        r_rw    <= AluRd;
        r_busw  <= AluData;
      end else if (w_pop) begin
        r_regwr <= w_head_live;
        if (w_head_live) begin
          r_rw   <= r_rd[r_rptr];
          r_busw <= r_data[r_rptr];
        end
      end else begin
        r_regwr <= 1'b0;
      end
    end
  end

endmodule
